// File: rtl/interconnect_pkg.sv
// Shared types and helpers for the interconnect slice.
//   axi_rd_arb_state_e : state encoding of the AXI read arbiter
//   idx_width()        : bits needed to carry a requester index (at least 1)
package interconnect_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_AR,
      ARB_R
   } axi_rd_arb_state_e;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick. Searches req starting one position after
// ptr and wrapping modulo N, so the requester named by ptr has the lowest
// priority on this pick.
//   req       in  N   request vector
//   ptr       in  IW  index of the most recently served requester
//   gnt_oh    out N   one-hot grant
//   gnt_idx   out IW  binary index of the grant
//   gnt_valid out 1   at least one request is set
module rr_arbiter
   import interconnect_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt_oh,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_valid
);

   logic [IW-1:0] cand;

   always_comb begin
      gnt_oh    = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      cand      = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IW'((int'(ptr) + k) % N);
         if (!gnt_valid && req[cand]) begin
            gnt_valid    = 1'b1;
            gnt_idx      = cand;
            gnt_oh[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read master port (AR + R) between N_REQ requesters.
// One burst is outstanding at a time; the grant is held from AR issue until
// the RLAST handshake. The requester index is prefixed onto ARID and checked
// on return together with the beat count; violations set a sticky err_o.
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   s_ar_*                 per-requester AR channels (flattened vectors)
//   s_r_*                  per-requester RVALID/RREADY, shared data/resp/last/id
//   m_ar_*, m_r_*          master-side AR and R channels
//   err_o                  sticky protocol error (ID prefix or beat count)
//   busy_o                 arbiter is not idle
module axi_rd_arbiter
   import interconnect_pkg::*;
#(
   parameter  int N_REQ          = 2,
   parameter  int AXI_ADDR_WIDTH = 32,
   parameter  int AXI_DATA_WIDTH = 64,
   parameter  int AXI_ID_WIDTH   = 4,
   localparam int IDX_W          = idx_width(N_REQ),
   localparam int M_ID_W         = AXI_ID_WIDTH + IDX_W
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [N_REQ-1:0]                  s_ar_valid_i,
   output logic [N_REQ-1:0]                  s_ar_ready_o,
   input  logic [N_REQ*AXI_ADDR_WIDTH-1:0]   s_ar_addr_i,
   input  logic [N_REQ*8-1:0]                s_ar_len_i,
   input  logic [N_REQ*AXI_ID_WIDTH-1:0]     s_ar_id_i,
   output logic [N_REQ-1:0]                  s_r_valid_o,
   input  logic [N_REQ-1:0]                  s_r_ready_i,
   output logic [AXI_DATA_WIDTH-1:0]         s_r_data_o,
   output logic [1:0]                        s_r_resp_o,
   output logic                              s_r_last_o,
   output logic [AXI_ID_WIDTH-1:0]           s_r_id_o,
   output logic                              m_ar_valid_o,
   input  logic                              m_ar_ready_i,
   output logic [AXI_ADDR_WIDTH-1:0]         m_ar_addr_o,
   output logic [7:0]                        m_ar_len_o,
   output logic [M_ID_W-1:0]                 m_ar_id_o,
   input  logic                              m_r_valid_i,
   output logic                              m_r_ready_o,
   input  logic [AXI_DATA_WIDTH-1:0]         m_r_data_i,
   input  logic [1:0]                        m_r_resp_i,
   input  logic                              m_r_last_i,
   input  logic [M_ID_W-1:0]                 m_r_id_i,
   output logic                              err_o,
   output logic                              busy_o
);

   axi_rd_arb_state_e state_q, state_d;
   logic [IDX_W-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [7:0]        beat_cnt_q, beat_cnt_d;
   logic [7:0]        len_q, len_d;
   logic              err_q, err_d;

   logic [AXI_ADDR_WIDTH-1:0] ar_addr [N_REQ];
   logic [7:0]                ar_len  [N_REQ];
   logic [AXI_ID_WIDTH-1:0]   ar_id   [N_REQ];

   logic [N_REQ-1:0] arb_oh;
   logic [IDX_W-1:0] arb_idx;
   logic             arb_valid;
   logic [7:0]       arb_len;
   logic             r_hs;

   for (genvar r = 0; r < N_REQ; r++) begin : g_unpack
      assign ar_addr[r] = s_ar_addr_i[r*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
      assign ar_len[r]  = s_ar_len_i[r*8 +: 8];
      assign ar_id[r]   = s_ar_id_i[r*AXI_ID_WIDTH +: AXI_ID_WIDTH];
   end

   rr_arbiter #(
      .N  (N_REQ),
      .IW (IDX_W)
   ) u_rr (
      .req       (s_ar_valid_i),
      .ptr       (rr_ptr_q),
      .gnt_oh    (arb_oh),
      .gnt_idx   (arb_idx),
      .gnt_valid (arb_valid)
   );

   // Length of the winning request, selected with the one-hot grant
   always_comb begin
      arb_len = '0;
      for (int r = 0; r < N_REQ; r++) begin
         if (arb_oh[r]) begin
            arb_len = arb_len | ar_len[r];
         end
      end
   end

   // AR payload and R payload are steered combinationally; only the
   // handshake qualifiers depend on the state.
   assign m_ar_addr_o = ar_addr[grant_q];
   assign m_ar_len_o  = ar_len[grant_q];
   assign m_ar_id_o   = {grant_q, ar_id[grant_q]};
   assign s_r_data_o  = m_r_data_i;
   assign s_r_resp_o  = m_r_resp_i;
   assign s_r_last_o  = m_r_last_i;
   assign s_r_id_o    = m_r_id_i[AXI_ID_WIDTH-1:0];
   assign r_hs        = m_r_valid_i && s_r_ready_i[grant_q];
   assign err_o       = err_q;
   assign busy_o      = (state_q != ARB_IDLE);

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      rr_ptr_d     = rr_ptr_q;
      beat_cnt_d   = beat_cnt_q;
      len_d        = len_q;
      err_d        = err_q;
      s_ar_ready_o = '0;
      s_r_valid_o  = '0;
      m_ar_valid_o = 1'b0;
      m_r_ready_o  = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (arb_valid) begin
               grant_d = arb_idx;
               len_d   = arb_len;
               state_d = ARB_AR;
            end
         end
         ARB_AR: begin
            m_ar_valid_o          = s_ar_valid_i[grant_q];
            s_ar_ready_o[grant_q] = m_ar_ready_i;
            // A requester withdrawing ARVALID breaks AXI; flag it and re-arbitrate
            if (!s_ar_valid_i[grant_q]) begin
               err_d   = 1'b1;
               state_d = ARB_IDLE;
            end else if (m_ar_ready_i) begin
               beat_cnt_d = '0;
               state_d    = ARB_R;
            end
         end
         ARB_R: begin
            s_r_valid_o[grant_q] = m_r_valid_i;
            m_r_ready_o          = s_r_ready_i[grant_q];
            if (r_hs) begin
               beat_cnt_d = beat_cnt_q + 8'd1;
               // beat_cnt_q counts beats already accepted, so the final beat
               // must arrive exactly when it equals ARLEN
               if (m_r_id_i[M_ID_W-1 -: IDX_W] != grant_q) begin
                  err_d = 1'b1;
               end
               if (m_r_last_i != (beat_cnt_q == len_q)) begin
                  err_d = 1'b1;
               end
               if (m_r_last_i) begin
                  rr_ptr_d = grant_q;
                  state_d  = ARB_IDLE;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ARB_IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= IDX_W'(N_REQ - 1);
         beat_cnt_q <= '0;
         len_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         len_q      <= len_d;
         err_q      <= err_d;
      end
   end

endmodule
